// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the round-robin shared-ALU controller.
package alu_arb_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_AND = 2'b01,
        OP_OR  = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        HOLD = 2'b10
    } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ADD/AND/OR/XOR unit; define ALU_ARB_SAT_EN to make ADD saturate on overflow.
module alu_core
    import alu_arb_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0] sum;

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        result = '0;
        carry  = 1'b0;
        unique case (op)
            OP_ADD: begin
`ifdef ALU_ARB_SAT_EN
                if (sum[WIDTH]) begin
                    result = '1;
                    carry  = 1'b1;
                end else begin
                    result = sum[WIDTH-1:0];
                end
`else
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
`endif
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between two requesters; result held under valid/ready.
// Build option ALU_ARB_SAT_EN (in alu_core) selects saturating ADD.
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [1:0]       op0,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic             owner_q, owner_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             valid_q, valid_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;

    logic             win;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_result),
        .carry  (alu_carry)
    );

    // A tie goes to the requester not granted last; a lone request wins outright.
    assign win = (req == 2'b11) ? ~last_q : req[1];

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        gnt_d    = 2'b00;
        valid_d  = valid_q;
        id_d     = id_q;
        result_d = result_q;
        carry_d  = carry_q;
        unique case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    last_d  = win;
                    owner_d = win;
                    op_d    = win ? op_e'(op1) : op_e'(op0);
                    a_d     = win ? a1 : a0;
                    b_d     = win ? b1 : b0;
                    gnt_d   = win ? 2'b10 : 2'b01;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_result;
                carry_d  = alu_carry;
                id_d     = owner_q;
                valid_d  = 1'b1;
                state_d  = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            gnt_q    <= 2'b00;
            valid_q  <= 1'b0;
            id_q     <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            gnt_q    <= gnt_d;
            valid_q  <= valid_d;
            id_q     <= id_d;
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = (state_q != IDLE);
    assign res_valid = valid_q;
    assign res_id    = id_q;
    assign result    = result_q;
    assign carry     = carry_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter; expectations are hand-computed.
module tb_alu_share_arbiter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req;
    logic [1:0]   op0, op1;
    logic [W-1:0] a0, b0, a1, b1;
    logic [1:0]   gnt;
    logic         busy;
    logic         res_valid;
    logic         res_ready;
    logic         res_id;
    logic [W-1:0] result;
    logic         carry;

    int n_tests = 0;
    int n_fail  = 0;

    alu_share_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .op0       (op0),
        .op1       (op1),
        .a0        (a0),
        .b0        (b0),
        .a1        (a1),
        .b1        (b1),
        .gnt       (gnt),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .result    (result),
        .carry     (carry)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, ".gnt"},       32'(gnt),       32'h0);
        check({tag, ".busy"},      32'(busy),      32'h0);
        check({tag, ".res_valid"}, 32'(res_valid), 32'h0);
        check({tag, ".res_id"},    32'(res_id),    32'h0);
        check({tag, ".result"},    32'(result),    32'h0);
        check({tag, ".carry"},     32'(carry),     32'h0);
    endtask

    logic [1:0]   exp_gnt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [W-1:0] exp_res [2] = '{8'h33, 8'h55};
    logic [W-1:0] hold_res;

    initial begin
        rst_n = 1'b0; req = 2'b00; res_ready = 1'b0;
        op0 = 2'b00; op1 = 2'b00; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check_idle_reset("reset");

        // Single request from 0: ADD 05+03.
        req = 2'b01; op0 = 2'b00; a0 = 8'h05; b0 = 8'h03;
        tick();
        check("add0.gnt", 32'(gnt), 32'h1);
        check("add0.busy", 32'(busy), 32'h1);
        check("add0.valid_early", 32'(res_valid), 32'h0);
        req = 2'b00;
        tick();
        check("add0.gnt_pulse", 32'(gnt), 32'h0);
        check("add0.valid", 32'(res_valid), 32'h1);
        check("add0.result", 32'(result), 32'h08);
        check("add0.carry", 32'(carry), 32'h0);
        check("add0.id", 32'(res_id), 32'h0);
        res_ready = 1'b1;
        tick();
        check("add0.valid_clr", 32'(res_valid), 32'h0);
        check("add0.busy_clr", 32'(busy), 32'h0);
        res_ready = 1'b0;

        // Single request from 1: ADD F0+20 overflows.
        req = 2'b10; op1 = 2'b00; a1 = 8'hF0; b1 = 8'h20;
        tick();
        check("add1.gnt", 32'(gnt), 32'h2);
        req = 2'b00;
        tick();
        check("add1.valid", 32'(res_valid), 32'h1);
        check("add1.id", 32'(res_id), 32'h1);
`ifdef ALU_ARB_SAT_EN
        check("add1.result", 32'(result), 32'hFF);
`else
        check("add1.result", 32'(result), 32'h10);
`endif
        check("add1.carry", 32'(carry), 32'h1);
        res_ready = 1'b1;
        tick();

        // Both requesting, consumer always ready: grants alternate starting at 0.
        req = 2'b11;
        op0 = 2'b10; a0 = 8'h12; b0 = 8'h21;
        op1 = 2'b11; a1 = 8'hAA; b1 = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("rr%0d.gnt", k), 32'(gnt), 32'(exp_gnt[k]));
            tick();
            check($sformatf("rr%0d.valid", k), 32'(res_valid), 32'h1);
            check($sformatf("rr%0d.id", k), 32'(res_id), 32'(k % 2));
            check($sformatf("rr%0d.result", k), 32'(result), 32'(exp_res[k % 2]));
            check($sformatf("rr%0d.carry", k), 32'(carry), 32'h0);
            tick();
            check($sformatf("rr%0d.idle", k), 32'(busy), 32'h0);
        end

        // Back-pressure: consumer stalls five cycles in HOLD.
        res_ready = 1'b0;
        tick();
        check("bp.gnt", 32'(gnt), 32'h1);
        tick();
        hold_res = 8'h33;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("bp%0d.valid", k), 32'(res_valid), 32'h1);
            check($sformatf("bp%0d.result", k), 32'(result), 32'(hold_res));
            check($sformatf("bp%0d.id", k), 32'(res_id), 32'h0);
            check($sformatf("bp%0d.gnt", k), 32'(gnt), 32'h0);
        end
        res_ready = 1'b1;
        tick();
        check("bp.release_valid", 32'(res_valid), 32'h0);
        check("bp.release_busy", 32'(busy), 32'h0);
        tick();
        check("bp.next_gnt", 32'(gnt), 32'h2);
        req = 2'b00;
        tick();
        check("bp.next_id", 32'(res_id), 32'h1);
        tick();
        res_ready = 1'b0;

        // Reset asserted during EXEC of AND 0F&3C.
        req = 2'b01; op0 = 2'b01; a0 = 8'h0F; b0 = 8'h3C;
        tick();
        check("rst.gnt_before", 32'(gnt), 32'h1);
        req = 2'b00;
        rst_n = 1'b0;
        #1;
        check_idle_reset("rst.async");
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        check_idle_reset("rst.after");

        // After reset the pointer favours requester 0 again; AND/OR on C3,5A.
        res_ready = 1'b1; req = 2'b11;
        op0 = 2'b01; a0 = 8'hC3; b0 = 8'h5A;
        op1 = 2'b10; a1 = 8'hC3; b1 = 8'h5A;
        tick();
        check("logic.gnt0", 32'(gnt), 32'h1);
        tick();
        check("logic.and", 32'(result), 32'h42);
        check("logic.and_carry", 32'(carry), 32'h0);
        check("logic.and_id", 32'(res_id), 32'h0);
        tick();
        tick();
        check("logic.gnt1", 32'(gnt), 32'h2);
        req = 2'b00;
        tick();
        check("logic.or", 32'(result), 32'hDB);
        check("logic.or_carry", 32'(carry), 32'h0);
        check("logic.or_id", 32'(res_id), 32'h1);
        tick();
        check("logic.idle", 32'(busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
